// File: rtl/bus_hold_arbiter_if.sv
// bus_hold_arbiter_if: 8088 hold/grant handshake between requesters, CPU and arbiter
interface bus_hold_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int ID_W = $clog2(N_REQ);
  logic [N_REQ-1:0] REQ;
  logic             HLDA;
  logic             HOLD;
  logic [N_REQ-1:0] GNT;
  logic [ID_W-1:0]  GNT_ID;
  logic             BUS_EN;
  logic             TIMEOUT;
  modport master (input REQ, HLDA, output HOLD, GNT, GNT_ID, BUS_EN, TIMEOUT);
  modport slave  (output REQ, HLDA, input HOLD, GNT, GNT_ID, BUS_EN, TIMEOUT);
endinterface

// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter: round-robin sharing of the 8088 local bus via HOLD/HLDA, CPU regains the bus between grants
module bus_hold_arbiter #(
  parameter int N_REQ    = 2,
  parameter int MAX_HOLD = 256,
  parameter int CNT_W    = 16
) (
  input logic                 CLK,
  input logic                 RESET_N,
  bus_hold_arbiter_if.master  bus
);
  localparam int ID_W = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, HOLD_REQ, GRANT, RELEASE} state_t;
  state_t           state_q, state_d;
  logic             hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  win, idx;
  logic             found;
  // round-robin pick: first set REQ bit scanning upward from the pointer with wrap
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % N_REQ);
      if (!found && bus.REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  // next-state and registered outputs; RELEASE ignores REQ so the CPU always gets the bus back
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: begin
        if (|bus.REQ) begin
          state_d = HOLD_REQ;
          hold_d  = 1'b1;
        end
      end
      HOLD_REQ: begin
        if (bus.HLDA) begin
          state_d  = found ? GRANT : RELEASE;
          hold_d   = found;
          gnt_d    = found ? (N_REQ'(1) << win) : '0;
          gnt_id_d = found ? win : gnt_id_q;
          cnt_d    = found ? CNT_W'(1) : '0;
        end
      end
      GRANT: begin
        if (!bus.HLDA || !bus.REQ[gnt_id_q] || (MAX_HOLD != 0 && cnt_q == CNT_W'(MAX_HOLD))) begin
          state_d   = RELEASE;
          hold_d    = 1'b0;
          gnt_d     = '0;
          cnt_d     = '0;
          ptr_d     = ID_W'((int'(gnt_id_q) + 1) % N_REQ);
          timeout_d = bus.HLDA && bus.REQ[gnt_id_q];
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        hold_d = 1'b0;
        gnt_d  = '0;
        if (!bus.HLDA) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low reset that overrides any tenure
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      hold_q    <= 1'b0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end
  assign bus.HOLD    = hold_q;
  assign bus.GNT     = gnt_q;
  assign bus.GNT_ID  = gnt_id_q;
  assign bus.TIMEOUT = timeout_q;
  assign bus.BUS_EN  = |gnt_q & bus.HLDA;
endmodule

// File: tb/tb_bus_hold_arbiter.sv
// tb_bus_hold_arbiter: scenario tasks plus a tenure scoreboard for the hold arbiter
module tb_bus_hold_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bus_hold_arbiter_if #(.N_REQ(2)) ia ();
  bus_hold_arbiter_if #(.N_REQ(2)) ib ();
  bus_hold_arbiter #(.N_REQ(2), .MAX_HOLD(256), .CNT_W(16)) u_a (.CLK(clk), .RESET_N(rst_n), .bus(ia));
  bus_hold_arbiter #(.N_REQ(2), .MAX_HOLD(4),   .CNT_W(16)) u_b (.CLK(clk), .RESET_N(rst_n), .bus(ib));
  typedef struct packed {
    logic [1:0] gnt;
    int         len;
  } tenure_t;
  tenure_t qa[$];
  tenure_t qb[$];
  int errors = 0;
  int checks = 0;
  // scoreboard: every grant tenure must match the next expected winner and length
  task automatic monitor();
    logic [1:0] pa = 2'b00;
    logic [1:0] pb = 2'b00;
    int ca = 0;
    int cb = 0;
    tenure_t t;
    forever begin
      @(negedge clk);
      if (ia.GNT !== 2'b00 && pa === 2'b00) begin
        checks++;
        if (qa.size() == 0) begin errors++; $display("FAIL a_unexpected_grant got=%b want=none", ia.GNT); end
        else if (ia.GNT !== qa[0].gnt) begin errors++; $display("FAIL a_grant got=%b want=%b", ia.GNT, qa[0].gnt); end
        ca = 1;
      end else if (ia.GNT !== 2'b00) begin
        ca++;
        checks++;
        if (ia.GNT !== pa) begin errors++; $display("FAIL a_grant_stable got=%b want=%b", ia.GNT, pa); end
      end else if (pa !== 2'b00 && qa.size() > 0) begin
        t = qa.pop_front();
        checks++;
        if (ca != t.len) begin errors++; $display("FAIL a_tenure_len got=%0d want=%0d", ca, t.len); end
      end
      pa = ia.GNT;
      if (ib.GNT !== 2'b00 && pb === 2'b00) begin
        checks++;
        if (qb.size() == 0) begin errors++; $display("FAIL b_unexpected_grant got=%b want=none", ib.GNT); end
        else if (ib.GNT !== qb[0].gnt) begin errors++; $display("FAIL b_grant got=%b want=%b", ib.GNT, qb[0].gnt); end
        cb = 1;
      end else if (ib.GNT !== 2'b00) begin
        cb++;
      end else if (pb !== 2'b00 && qb.size() > 0) begin
        t = qb.pop_front();
        checks++;
        if (cb != t.len) begin errors++; $display("FAIL b_tenure_len got=%0d want=%0d", cb, t.len); end
      end
      pb = ib.GNT;
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    ia.REQ = 2'b11; ia.HLDA = 1'b1;
    ib.REQ = 2'b11; ib.HLDA = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ia.HOLD !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b want=0", ia.HOLD); end
    checks++; if (ia.GNT !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b want=00", ia.GNT); end
    checks++; if (ia.GNT_ID !== 1'b0) begin errors++; $display("FAIL reset_gnt_id got=%b want=0", ia.GNT_ID); end
    checks++; if (ia.TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b want=0", ia.TIMEOUT); end
    checks++; if ({ib.HOLD, ib.GNT, ib.GNT_ID, ib.TIMEOUT} !== 5'b0) begin errors++; $display("FAIL reset_b got=%b want=00000", {ib.HOLD, ib.GNT, ib.GNT_ID, ib.TIMEOUT}); end
    ia.REQ = 2'b00; ia.HLDA = 1'b0;
    ib.REQ = 2'b00; ib.HLDA = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single_request();
    ia.REQ = 2'b01;
    @(negedge clk);
    checks++; if (ia.HOLD !== 1'b1) begin errors++; $display("FAIL single_hold got=%b want=1", ia.HOLD); end
    repeat (2) @(negedge clk);
    checks++; if ({ia.HOLD, ia.GNT} !== 3'b100) begin errors++; $display("FAIL single_wait got=%b want=100", {ia.HOLD, ia.GNT}); end
    ia.HLDA = 1'b1;
    qa.push_back('{gnt: 2'b01, len: 5});
    @(negedge clk);
    checks++; if ({ia.GNT, ia.GNT_ID, ia.BUS_EN} !== 4'b0101) begin errors++; $display("FAIL single_grant got=%b want=0101", {ia.GNT, ia.GNT_ID, ia.BUS_EN}); end
    repeat (4) @(negedge clk);
    ia.REQ = 2'b00;
    @(negedge clk);
    checks++; if ({ia.HOLD, ia.GNT} !== 3'b000) begin errors++; $display("FAIL single_release got=%b want=000", {ia.HOLD, ia.GNT}); end
    ia.HLDA = 1'b0;
    @(negedge clk);
    checks++; if (ia.HOLD !== 1'b0) begin errors++; $display("FAIL single_idle_hold got=%b want=0", ia.HOLD); end
  endtask
  task automatic test_round_robin();
    logic [1:0] exp;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 1) ? 2'b10 : 2'b01;
      ia.REQ = 2'b11;
      @(negedge clk);
      checks++; if (ia.HOLD !== 1'b1) begin errors++; $display("FAIL rr_hold_%0d got=%b want=1", k, ia.HOLD); end
      ia.HLDA = 1'b1;
      qa.push_back('{gnt: exp, len: 3});
      @(negedge clk);
      checks++; if (ia.GNT !== exp) begin errors++; $display("FAIL rr_grant_%0d got=%b want=%b", k, ia.GNT, exp); end
      repeat (2) @(negedge clk);
      ia.REQ = 2'b11 & ~exp;
      @(negedge clk);
      checks++; if ({ia.HOLD, ia.GNT} !== 3'b000) begin errors++; $display("FAIL rr_release_%0d got=%b want=000", k, {ia.HOLD, ia.GNT}); end
      ia.HLDA = 1'b0;
      ia.REQ = 2'b11;
      @(negedge clk);
      checks++; if (ia.HOLD !== 1'b0) begin errors++; $display("FAIL rr_cpu_back_%0d got=%b want=0", k, ia.HOLD); end
    end
    ia.REQ = 2'b00;
    @(negedge clk);
    ia.HLDA = 1'b1;
    @(negedge clk);
    ia.HLDA = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_timeout();
    int pulses = 0;
    ib.REQ = 2'b10;
    @(negedge clk);
    checks++; if (ib.HOLD !== 1'b1) begin errors++; $display("FAIL to_hold got=%b want=1", ib.HOLD); end
    ib.HLDA = 1'b1;
    qb.push_back('{gnt: 2'b10, len: 4});
    repeat (5) begin
      @(negedge clk);
      if (ib.TIMEOUT === 1'b1) pulses++;
    end
    checks++; if ({ib.HOLD, ib.GNT, ib.TIMEOUT} !== 4'b0001) begin errors++; $display("FAIL to_cut got=%b want=0001", {ib.HOLD, ib.GNT, ib.TIMEOUT}); end
    ib.HLDA = 1'b0;
    @(negedge clk);
    if (ib.TIMEOUT === 1'b1) pulses++;
    checks++; if (ib.HOLD !== 1'b0) begin errors++; $display("FAIL to_cpu_back got=%b want=0", ib.HOLD); end
    @(negedge clk);
    checks++; if (ib.HOLD !== 1'b1) begin errors++; $display("FAIL to_rehold got=%b want=1", ib.HOLD); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL to_pulses got=%0d want=1", pulses); end
    ib.REQ = 2'b00;
    ib.HLDA = 1'b1;
    @(negedge clk);
    ib.HLDA = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_withdrawn();
    ia.REQ = 2'b01;
    @(negedge clk);
    checks++; if (ia.HOLD !== 1'b1) begin errors++; $display("FAIL wd_hold got=%b want=1", ia.HOLD); end
    ia.REQ = 2'b00;
    @(negedge clk);
    checks++; if (ia.HOLD !== 1'b1) begin errors++; $display("FAIL wd_hold_kept got=%b want=1", ia.HOLD); end
    ia.HLDA = 1'b1;
    @(negedge clk);
    checks++; if ({ia.HOLD, ia.GNT} !== 3'b000) begin errors++; $display("FAIL wd_release got=%b want=000", {ia.HOLD, ia.GNT}); end
    ia.HLDA = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_spurious_hlda();
    ia.HLDA = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({ia.HOLD, ia.GNT} !== 3'b000) begin errors++; $display("FAIL spurious_hlda got=%b want=000", {ia.HOLD, ia.GNT}); end
    ia.HLDA = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_protocol_error();
    ia.REQ = 2'b01;
    @(negedge clk);
    ia.HLDA = 1'b1;
    qa.push_back('{gnt: 2'b01, len: 2});
    @(negedge clk);
    checks++; if (ia.BUS_EN !== 1'b1) begin errors++; $display("FAIL pe_bus_en_on got=%b want=1", ia.BUS_EN); end
    @(negedge clk);
    ia.HLDA = 1'b0;
    #1;
    checks++; if ({ia.BUS_EN, ia.GNT} !== 3'b001) begin errors++; $display("FAIL pe_bus_en_off got=%b want=001", {ia.BUS_EN, ia.GNT}); end
    @(negedge clk);
    checks++; if ({ia.HOLD, ia.GNT} !== 3'b000) begin errors++; $display("FAIL pe_release got=%b want=000", {ia.HOLD, ia.GNT}); end
    ia.REQ = 2'b00;
    @(negedge clk);
  endtask
  task automatic test_reset_mid_grant();
    ia.REQ = 2'b10;
    @(negedge clk);
    ia.HLDA = 1'b1;
    qa.push_back('{gnt: 2'b10, len: 2});
    repeat (2) @(negedge clk);
    checks++; if (ia.GNT_ID !== 1'b1) begin errors++; $display("FAIL mid_gnt_id got=%b want=1", ia.GNT_ID); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({ia.HOLD, ia.GNT, ia.GNT_ID, ia.TIMEOUT} !== 5'b0) begin errors++; $display("FAIL mid_reset got=%b want=00000", {ia.HOLD, ia.GNT, ia.GNT_ID, ia.TIMEOUT}); end
    rst_n = 1'b1;
    ia.REQ = 2'b00;
    ia.HLDA = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    test_reset();
    fork
      monitor();
    join_none
    test_single_request();
    test_round_robin();
    test_timeout();
    test_withdrawn();
    test_spurious_hlda();
    test_protocol_error();
    test_reset_mid_grant();
    checks++; if (qa.size() + qb.size() != 0) begin errors++; $display("FAIL pending_tenures got=%0d want=0", qa.size() + qb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
